// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared constants for the single-byte I2C master: FSM state
//                encodings, quarter-phase codes and bits per data slot.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    // FSM state encodings
    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] START = 4'd1;
    localparam logic [3:0] ADDR  = 4'd2;
    localparam logic [3:0] ACK1  = 4'd3;
    localparam logic [3:0] WDATA = 4'd4;
    localparam logic [3:0] ACK2  = 4'd5;
    localparam logic [3:0] RDATA = 4'd6;
    localparam logic [3:0] MNACK = 4'd7;
    localparam logic [3:0] STOP  = 4'd8;

    // Quarter phases inside one SCL period
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // Bits carried by each byte-wide phase
    localparam int SLOT_BITS = 8;

    // True for states whose SCL follows the regular low-low-high-high slot shape
    function automatic logic is_bit_slot(input logic [3:0] st);
        return (st == ADDR) || (st == ACK1) || (st == WDATA) ||
               (st == ACK2) || (st == RDATA) || (st == MNACK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_quarter_tick.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_quarter_tick
//  Description : Divides clk into SCL quarter-period ticks and tracks the
//                2-bit quarter phase. Both counters hold at zero while en=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_quarter_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       qtick,
    output logic [1:0] q
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] TERM = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;

    assign qtick = en && (div_q == TERM);

    // Quarter divider and phase counter; both restart from zero each transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            q     <= 2'd0;
        end else if (!en) begin
            div_q <= '0;
            q     <= 2'd0;
        end else if (qtick) begin
            div_q <= '0;
            q     <= q + 2'd1;
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/master_i2c.sv
`default_nettype none
// ============================================================================
//  Module      : master_i2c
//  Description : Single-byte I2C master. START, 7-bit address + R/W, address
//                ACK check, one write or read byte, STOP. Open-drain bus,
//                single master, no clock stretching.
//  Revision    : 1.0 - initial release
// ============================================================================
module master_i2c
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] device_address,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    inout  wire        scl,
    inout  wire        sda
);

    localparam logic [2:0] LAST_BIT = 3'(SLOT_BITS - 1);

    logic [3:0] state_q,     state_d;
    logic [2:0] bitcnt_q,    bitcnt_d;
    logic [7:0] shreg_q,     shreg_d;
    logic [7:0] wdata_q,     wdata_d;
    logic [7:0] rdata_q,     rdata_d;
    logic       rw_q,        rw_d;
    logic       ack_error_q, ack_error_d;
    logic       sample_q,    sample_d;
    logic [1:0] sda_sync_q;

    logic       qtick;
    logic [1:0] q;
    logic       sda_s;
    logic       scl_low;
    logic       sda_low;

    i2c_quarter_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_qtick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q != IDLE),
        .qtick (qtick),
        .q     (q)
    );

    assign sda_s     = sda_sync_q[1];
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == STOP) && qtick && (q == Q3);
    assign rdata     = rdata_q;
    assign ack_error = ack_error_q;

    // Next-state logic: transitions happen at quarter ticks, except the IDLE accept
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rw_d        = rw_q;
        ack_error_d = ack_error_q;
        sample_d    = sample_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = START;
                    shreg_d     = {device_address, rw};
                    rw_d        = rw;
                    wdata_d     = wdata;
                    ack_error_d = 1'b0;
                    bitcnt_d    = 3'd0;
                end
            end
            START: begin
                if (qtick && (q == Q3)) begin
                    state_d  = ADDR;
                    bitcnt_d = 3'd0;
                end
            end
            ADDR, WDATA: begin
                if (qtick && (q == Q3)) begin
                    if (bitcnt_q == LAST_BIT) begin
                        state_d = (state_q == ADDR) ? ACK1 : ACK2;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        shreg_d  = {shreg_q[6:0], 1'b0};
                    end
                end
            end
            ACK1: begin
                if (qtick && (q == Q2)) begin
                    sample_d = sda_s;
                end
                if (qtick && (q == Q3)) begin
                    bitcnt_d = 3'd0;
                    if (sample_q) begin
                        ack_error_d = 1'b1;
                        state_d     = STOP;
                    end else if (rw_q) begin
                        state_d = RDATA;
                    end else begin
                        state_d = WDATA;
                        shreg_d = wdata_q;
                    end
                end
            end
            ACK2: begin
                if (qtick && (q == Q2)) begin
                    sample_d = sda_s;
                end
                if (qtick && (q == Q3)) begin
                    if (sample_q) begin
                        ack_error_d = 1'b1;
                    end
                    state_d = STOP;
                end
            end
            RDATA: begin
                if (qtick && (q == Q2)) begin
                    rdata_d = {rdata_q[6:0], sda_s};
                end
                if (qtick && (q == Q3)) begin
                    if (bitcnt_q == LAST_BIT) begin
                        state_d = MNACK;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end
            MNACK: begin
                if (qtick && (q == Q3)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (qtick && (q == Q3)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset releases the bus without a STOP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bitcnt_q    <= 3'd0;
            shreg_q     <= 8'd0;
            wdata_q     <= 8'd0;
            rdata_q     <= 8'd0;
            rw_q        <= 1'b0;
            ack_error_q <= 1'b0;
            sample_q    <= 1'b1;
            sda_sync_q  <= 2'b11;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rw_q        <= rw_d;
            ack_error_q <= ack_error_d;
            sample_q    <= sample_d;
            sda_sync_q  <= {sda_sync_q[0], sda};
        end
    end

    // Line drive decode: 1 means pull the wire low, 0 means release it
    always_comb begin
        scl_low = 1'b0;
        sda_low = 1'b0;
        if (is_bit_slot(state_q)) begin
            scl_low = (q == Q0) || (q == Q1);
            if ((state_q == ADDR) || (state_q == WDATA)) begin
                sda_low = ~shreg_q[7];
            end
        end else if (state_q == START) begin
            sda_low = (q == Q2) || (q == Q3);
        end else if (state_q == STOP) begin
            scl_low = (q == Q0);
            sda_low = (q == Q0) || (q == Q1);
        end
    end

    assign scl = scl_low ? 1'b0 : 1'bz;
    assign sda = sda_low ? 1'b0 : 1'bz;

endmodule
`default_nettype wire
